// File: rtl/matrix_mult_sequencer.sv
// Inner-product initiator: walks C[i][j] in row-major order, presenting row i of A
// and column j of B to an inner-product engine and storing each scalar result.
module matrix_mult_sequencer #(
  parameter  int N = 4,
  localparam int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W*N*N-1:0] a_flat,
  input  logic [W*N*N-1:0] b_flat,
  output logic             busy,
  output logic             done,
  output logic [W*N*N-1:0] c_flat,
  output logic [W*N-1:0]   ip_row,
  output logic [W*N-1:0]   ip_column,
  output logic             ip_row_stb,
  output logic             ip_column_stb,
  input  logic             ip_row_ack,
  input  logic             ip_column_ack,
  output logic             ip_out_ack,
  input  logic [W-1:0]     ip_out,
  input  logic             ip_out_stb
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESULT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [W*N*N-1:0]   r_a;
  logic [W*N*N-1:0]   r_b;
  logic [W*N*N-1:0]   r_c;
  logic [IW-1:0]      r_i;
  logic [IW-1:0]      r_j;
  logic               r_row_acked;
  logic               r_col_acked;
  logic               r_busy;
  logic               r_done;
  logic [W*N-1:0]     r_ip_row;
  logic [W*N-1:0]     r_ip_column;
  logic               r_row_stb;
  logic               r_col_stb;
  logic               r_out_ack;

  logic [IW-1:0]      w_next_i;
  logic [IW-1:0]      w_next_j;
  logic               w_last;
  logic               w_row_ok;
  logic               w_col_ok;

  function automatic logic [W*N-1:0] get_row(input logic [W*N*N-1:0] m,
                                             input logic [IW-1:0]    idx);
    logic [W*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = m[(int'(idx)*N + k)*W +: W];
    return v;
  endfunction

  function automatic logic [W*N-1:0] get_col(input logic [W*N*N-1:0] m,
                                             input logic [IW-1:0]    idx);
    logic [W*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = m[(k*N + int'(idx))*W +: W];
    return v;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_i = r_i;
    w_next_j = r_j;
    w_last   = 1'b0;
    if (int'(r_j) < N-1) begin
      w_next_j = r_j + IW'(1);
    end else if (int'(r_i) < N-1) begin
      w_next_j = '0;
      w_next_i = r_i + IW'(1);
    end else begin
      w_last = 1'b1;
    end
  end

  // An ack counts as seen either from its latch or in the cycle it arrives.
  assign w_row_ok = r_row_acked | ip_row_ack;
  assign w_col_ok = r_col_acked | ip_column_ack;

  // NOTE: the latched operand matrices carry no reset; they are only read after
  // a start has loaded them, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_a <= a_flat;
      r_b <= b_flat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_row_acked <= 1'b0;
      r_col_acked <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ip_row    <= '0;
      r_ip_column <= '0;
      r_row_stb   <= 1'b0;
      r_col_stb   <= 1'b0;
      r_out_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_busy      <= 1'b1;
            r_ip_row    <= get_row(a_flat, '0);
            r_ip_column <= get_col(b_flat, '0);
            r_row_stb   <= 1'b1;
            r_col_stb   <= 1'b1;
            r_out_ack   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ip_row_ack && !r_row_acked) begin
            r_row_acked <= 1'b1;
            r_row_stb   <= 1'b0;
          end
          if (ip_column_ack && !r_col_acked) begin
            r_col_acked <= 1'b1;
            r_col_stb   <= 1'b0;
          end
          if (w_row_ok && w_col_ok) r_state <= S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          if (ip_out_stb) begin
            r_c[(int'(r_i)*N + int'(r_j))*W +: W] <= ip_out;
            r_out_ack <= 1'b0;
            r_state   <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          r_row_acked <= 1'b0;
          r_col_acked <= 1'b0;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i         <= w_next_i;
            r_j         <= w_next_j;
            r_ip_row    <= get_row(r_a, w_next_i);
            r_ip_column <= get_col(r_b, w_next_j);
            r_row_stb   <= 1'b1;
            r_col_stb   <= 1'b1;
            r_out_ack   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign c_flat        = r_c;
  assign ip_row        = r_ip_row;
  assign ip_column     = r_ip_column;
  assign ip_row_stb    = r_row_stb;
  assign ip_column_stb = r_col_stb;
  assign ip_out_ack    = r_out_ack;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer (N=2) with a configurable
// inner-product responder standing in for the engine.
module tb_matrix_mult_sequencer;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int MW = W*N*N;
  localparam int VW = W*N;

  localparam logic [W-1:0] ONE   = 32'h3F80_0000;
  localparam logic [W-1:0] TWO   = 32'h4000_0000;
  localparam logic [W-1:0] THREE = 32'h4040_0000;
  localparam logic [W-1:0] FOUR  = 32'h4080_0000;
  localparam logic [W-1:0] TEN   = 32'h4120_0000;

  localparam logic [MW-1:0] A_ID  = {ONE, 32'h0, 32'h0, ONE};
  localparam logic [MW-1:0] B_VAL = {FOUR, THREE, TWO, ONE};
  localparam logic [W-1:0]  BT00  = 32'hB000_0000;
  localparam logic [W-1:0]  BT01  = 32'hB000_0001;
  localparam logic [W-1:0]  BT10  = 32'hB000_0010;
  localparam logic [W-1:0]  BT11  = 32'hB000_0011;
  localparam logic [MW-1:0] B_TAG = {BT11, BT10, BT01, BT00};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] a_flat;
  logic [MW-1:0] b_flat;
  logic          busy;
  logic          done;
  logic [MW-1:0] c_flat;
  logic [VW-1:0] ip_row;
  logic [VW-1:0] ip_column;
  logic          ip_row_stb;
  logic          ip_column_stb;
  logic          ip_row_ack;
  logic          ip_column_ack;
  logic          ip_out_ack;
  logic [W-1:0]  ip_out;
  logic          ip_out_stb;

  always #5 clk = ~clk;

  matrix_mult_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_flat       (a_flat),
    .b_flat       (b_flat),
    .busy         (busy),
    .done         (done),
    .c_flat       (c_flat),
    .ip_row       (ip_row),
    .ip_column    (ip_column),
    .ip_row_stb   (ip_row_stb),
    .ip_column_stb(ip_column_stb),
    .ip_row_ack   (ip_row_ack),
    .ip_column_ack(ip_column_ack),
    .ip_out_ack   (ip_out_ack),
    .ip_out       (ip_out),
    .ip_out_stb   (ip_out_stb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder configuration and transaction log.
  int            cfg_rd    = 0;
  int            cfg_cd    = 0;
  int            cfg_res   = 2;
  bit            cfg_const = 1'b0;
  logic [W-1:0]  cfg_val   = '0;
  logic [VW-1:0] seen_row[$];
  logic [VW-1:0] seen_col[$];
  int            stab_err  = 0;
  int            skew_err  = 0;
  int            done_cnt  = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Engine model: constant result, or for an identity-like A row the B word
  // selected by the 1.0 element (exact product for A = I).
  function automatic logic [W-1:0] engine(input logic [VW-1:0] r, input logic [VW-1:0] c);
    logic [W-1:0] acc;
    acc = '0;
    if (cfg_const) return cfg_val;
    for (int k = 0; k < N; k++)
      if (r[k*W +: W] == ONE) acc = c[k*W +: W];
    return acc;
  endfunction

  initial begin
    logic [VW-1:0] row_q;
    logic [VW-1:0] col_q;
    int            mx;
    ip_row_ack    = 1'b0;
    ip_column_ack = 1'b0;
    ip_out_stb    = 1'b0;
    ip_out        = '0;
    forever begin
      @(negedge clk);
      if (rst && ip_row_stb && ip_column_stb && ip_out_ack) begin
        row_q = ip_row;
        col_q = ip_column;
        seen_row.push_back(row_q);
        seen_col.push_back(col_q);
        mx = (cfg_rd > cfg_cd) ? cfg_rd : cfg_cd;
        for (int c = 0; c <= mx; c++) begin
          if (c > 0) @(negedge clk);
          if (ip_row_stb && ip_row !== row_q) stab_err++;
          if (ip_column_stb && ip_column !== col_q) stab_err++;
          if (c > cfg_rd && c <= cfg_cd && (ip_row_stb !== 1'b0 || ip_column_stb !== 1'b1))
            skew_err++;
          ip_row_ack    = (c == cfg_rd);
          ip_column_ack = (c == cfg_cd);
        end
        @(negedge clk);
        ip_row_ack    = 1'b0;
        ip_column_ack = 1'b0;
        repeat (cfg_res) @(negedge clk);
        ip_out     = engine(row_q, col_q);
        ip_out_stb = 1'b1;
        @(negedge clk);
        ip_out_stb = 1'b0;
        ip_out     = '0;
      end
    end
  end

  task automatic run_start(input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int base;
    int n;
    rst    = 1'b0;
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;

    // 1: reset with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_flat = {$urandom, $urandom, $urandom, $urandom};
      b_flat = {$urandom, $urandom, $urandom, $urandom};
      start  = 1'($urandom_range(0, 1));
      #1;
      check("rst_ctrl", {busy, done, ip_row_stb, ip_column_stb, ip_out_ack}, 5'b0);
      check("rst_c", c_flat, '0);
      check("rst_ip_data", {ip_row, ip_column}, '0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", {busy, done, ip_row_stb, ip_column_stb, ip_out_ack}, 5'b0);

    // 2: identity A times B
    cfg_rd = 0; cfg_cd = 0; cfg_res = 3; cfg_const = 1'b0;
    seen_row.delete(); seen_col.delete();
    base = done_cnt;
    run_start(A_ID, B_VAL);
    check("s2_busy", busy, 1'b1);
    wait_done("s2", 300);
    check("s2_c", c_flat, B_VAL);
    check("s2_txns", seen_row.size(), 4);
    check("s2_done_pulses", done_cnt - base, 1);

    // 3: row ack three cycles before column ack
    cfg_rd = 0; cfg_cd = 3; cfg_res = 2;
    seen_row.delete(); seen_col.delete();
    stab_err = 0; skew_err = 0;
    run_start(A_ID, B_VAL);
    wait_done("s3", 300);
    check("s3_c", c_flat, B_VAL);
    check("s3_txns", seen_row.size(), 4);
    check("s3_skew", skew_err, 0);
    check("s3_stable", stab_err, 0);

    // 4: single-cycle result after 20 cycles, constant 10.0
    cfg_rd = 0; cfg_cd = 0; cfg_res = 20; cfg_const = 1'b1; cfg_val = TEN;
    seen_row.delete(); seen_col.delete();
    run_start(A_ID, B_TAG);
    wait_done("s4", 500);
    check("s4_c", c_flat, {TEN, TEN, TEN, TEN});
    check("s4_txns", seen_col.size(), 4);
    if (seen_col.size() == 4) begin
      check("s4_col0", seen_col[0], {BT10, BT00});
      check("s4_col1", seen_col[1], {BT11, BT01});
      check("s4_col2", seen_col[2], {BT10, BT00});
      check("s4_col3", seen_col[3], {BT11, BT01});
      check("s4_row0", seen_row[0], {32'h0, ONE});
      check("s4_row3", seen_row[3], {ONE, 32'h0});
    end

    // 5: restart attempt and A change mid-run
    cfg_res = 5; cfg_const = 1'b0;
    seen_row.delete(); seen_col.delete();
    base = done_cnt;
    run_start(A_ID, B_VAL);
    repeat (6) @(negedge clk);
    a_flat = '1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("s5", 300);
    check("s5_c", c_flat, B_VAL);
    check("s5_txns", seen_row.size(), 4);
    check("s5_done_pulses", done_cnt - base, 1);

    // 6: reset during WAIT_RESULT of element (1,0)
    cfg_res = 10;
    seen_row.delete(); seen_col.delete();
    base = done_cnt;
    run_start(A_ID, B_VAL);
    n = 0;
    while (!(seen_row.size() == 3 && busy && ip_out_ack && !ip_row_stb && !ip_column_stb)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s6_reached_wait", n < 300, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("s6_async_ctrl", {busy, done, ip_row_stb, ip_column_stb, ip_out_ack}, 5'b0);
    check("s6_async_c", c_flat, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("s6_no_partial_done", done_cnt - base, 0);
    check("s6_idle_busy", busy, 1'b0);
    cfg_res = 2;
    seen_row.delete(); seen_col.delete();
    run_start(A_ID, B_VAL);
    wait_done("s6_rerun", 300);
    check("s6_rerun_c", c_flat, B_VAL);
    check("s6_rerun_txns", seen_row.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_mult_sequencer.md
Name: matrix_mult_sequencer

Overview:
Initiator for the inner-product protocol. It owns two latched N x N IEEE-754 single-precision matrices A and B. For every (i,j) it presents row i of A and column j of B to an inner-product unit over the row/column stb/ack handshake, collects the scalar result, and writes it into C[i][j]. It sits between the top-level matrix multiplier control and the inner-product engine.

Parameters:
N, 4, matrix dimension and vector length (≥1); must equal the inner-product unit's number_of_elements.
W, 32, word width (localparam, IEEE-754 single; not overridable).

Ports:
clk  input  1  clock
rst  input  1  reset: asynchronous, active-low
start  input  1  request new multiply; accepted only in IDLE
a_flat  input  W*N*N  A, element (r,c) at [(r*N+c)*W +: W]
b_flat  input  W*N*N  B, same packing
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when C is complete
c_flat  output  W*N*N  result C, same packing
ip_row  output  W*N  row i of A; element k at [k*W +: W]
ip_column  output  W*N  column j of B; element k = B[k][j] at [k*W +: W]
ip_row_stb  output  1  row valid
ip_column_stb  output  1  column valid
ip_row_ack  input  1  row accepted
ip_column_ack  input  1  column accepted
ip_out_ack  output  1  sequencer ready to take a result
ip_out  input  W  scalar result
ip_out_stb  input  1  result valid (may be a single-cycle pulse)

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, c_flat=0, ip_row=0, ip_column=0, all stb outputs=0, ip_out_ack=0, i=j=0, ack latches cleared.
- IDLE:
  - start=1 → latch a_flat/b_flat into internal A/B, clear c_flat, i=j=0, busy=1, go to ISSUE.
  - Otherwise hold.
- ISSUE:
  - ip_row, ip_column driven from latched A row i / B column j, stable while either stb is high.
  - ip_row_stb=ip_column_stb=ip_out_ack=1.
  - Each ack is latched independently; acks may arrive in the same or different cycles.
  - Each stb drops the cycle after its own ack is seen.
  - When both acks are latched, go to WAIT_RESULT.
  - ip_out_ack is held high here because the engine requires it together with both stb signals before it will start.
- WAIT_RESULT:
  - ip_out_ack=1, both stb outputs=0.
  - On ip_out_stb=1, capture ip_out into c_flat[(i*N+j)*W +: W] in that cycle and go to ADVANCE.
  - ip_out_stb asserted in the same cycle as the final ack (still in ISSUE) is ignored; the engine cannot produce a result that early.
- ADVANCE:
  - ip_out_ack=0 for one cycle; clear ack latches.
  - If j<N-1: j++. Else if i<N-1: j=0, i++. Else go to DONE.
  - Otherwise go to ISSUE.
  - Order is row-major: j is the inner loop.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE. c_flat holds until the next accepted start.
- Boundaries:
  - start while busy is ignored.
  - a_flat/b_flat changes after start have no effect on the current run.
  - N=1 gives exactly one transaction.
  - Spurious acks in IDLE/WAIT_RESULT/ADVANCE are ignored.
  - A reset at any point aborts immediately to reset values; no partial done.
- Index counters are clog2(N) bits wide (minimum 1). No arithmetic is done on data; words pass through bit-exact.
- Latency per element: 1 cycle ISSUE minimum + engine latency + 1 ADVANCE.
- Total cycles from start to done ≥ N*N*(3+engine latency)+1.

Test Plan:
1. Reset: hold rst=0 with random inputs → all outputs 0, c_flat=0; release with start=0 → stays IDLE, busy=0.
2. N=2, real inner-product engine, A=I (0x3F800000 on diagonal, 0 elsewhere), B=[[1,2],[3,4]] → c_flat words in order 0x3F800000, 0x40000000, 0x40400000, 0x40800000. Exactly 4 stb transactions, one done pulse, busy=0 after.
3. Skewed acks with a responder model: row_ack 3 cycles before column_ack → ip_row_stb drops after its ack, ip_column_stb held until its ack, ip_row stable throughout, single result per element.
4. Responder returns a one-cycle ip_out_stb after a 20-cycle delay, value 0x41200000 for every element → every c_flat word is 0x41200000, no element skipped or duplicated (j order checked via the ip_column contents).
5. Start pulsed again mid-run and a_flat changed to all 0xFFFFFFFF → no restart, and C matches the originally latched A.
6. rst=0 asserted during WAIT_RESULT of element (1,0) → all stb outputs/busy/done drop asynchronously. A new start then completes a full run with correct C (as in scenario 2).
